// File: rtl/imdct_bram_arbiter_if.sv
// imdct_bram_arbiter_if: host/core command channels and BRAM port shared by imdct_bram_arbiter
interface imdct_bram_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 32
);
  logic               h_req, h_we, h_gnt, h_rvalid;
  logic [ADDRESS-1:0] h_addr;
  logic [WIDTH-1:0]   h_wdata, h_rdata;
  logic               c_req, c_we, c_gnt, c_rvalid, c_lock;
  logic [ADDRESS-1:0] c_addr;
  logic [WIDTH-1:0]   c_wdata, c_rdata;
  logic               en_bram, we_bram;
  logic [ADDRESS-1:0] addr_bram;
  logic [WIDTH-1:0]   din_bram, dout_bram;
  modport slave (
    input  h_req, h_we, h_addr, h_wdata, c_req, c_we, c_addr, c_wdata, c_lock, dout_bram,
    output h_gnt, h_rvalid, h_rdata, c_gnt, c_rvalid, c_rdata, en_bram, we_bram, addr_bram, din_bram
  );
  modport master (
    output h_req, h_we, h_addr, h_wdata, c_req, c_we, c_addr, c_wdata, c_lock, dout_bram,
    input  h_gnt, h_rvalid, h_rdata, c_gnt, c_rvalid, c_rdata, en_bram, we_bram, addr_bram, din_bram
  );
endinterface

// File: rtl/imdct_bram_arbiter.sv
// imdct_bram_arbiter: host/core arbiter for the single IMDCT BRAM port with core lock and tagged reads.
// BRAM_ARB_RR_EN selects round-robin contention priority; otherwise the core always wins.
module imdct_bram_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 32,
  parameter int RD_LAT  = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  imdct_bram_arbiter_if.slave bus
);
  typedef enum logic {OPEN, LOCKED} state_t;
  state_t             state_q, state_d;
  logic               locked, core_wins, h_gnt, c_gnt;
  logic               en_q, we_q, own_q, h_rvalid_q, c_rvalid_q;
  logic [ADDRESS-1:0] addr_q;
  logic [WIDTH-1:0]   din_q, h_rdata_q, c_rdata_q;
  logic [RD_LAT-1:0]  vld_q, tag_q;
  logic [RD_LAT:0]    vld_sh, tag_sh;
`ifdef BRAM_ARB_RR_EN
  logic last_q, last_d;
  assign core_wins = !last_q;
  assign last_d    = c_gnt ? 1'b1 : (h_gnt ? 1'b0 : last_q);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) last_q <= 1'b0;
    else       last_q <= last_d;
`else
  assign core_wins = 1'b1;
`endif
  // LOCKED only holds while c_lock stays high; the release cycle arbitrates as OPEN
  always_comb begin
    locked  = (state_q == LOCKED) && bus.c_lock;
    c_gnt   = !rst_i && bus.c_req && (locked || !bus.h_req || core_wins);
    h_gnt   = !rst_i && bus.h_req && !locked && !c_gnt;
    state_d = (locked || (c_gnt && bus.c_lock)) ? LOCKED : OPEN;
    vld_sh  = {vld_q, en_q && !we_q};
    tag_sh  = {tag_q, own_q};
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= OPEN;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      own_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      vld_q      <= '0;
      tag_q      <= '0;
      h_rvalid_q <= 1'b0;
      c_rvalid_q <= 1'b0;
      h_rdata_q  <= '0;
      c_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= h_gnt || c_gnt;
      we_q       <= c_gnt ? bus.c_we : (h_gnt && bus.h_we);
      own_q      <= c_gnt;
      if (h_gnt || c_gnt) begin
        addr_q <= c_gnt ? bus.c_addr : bus.h_addr;
        din_q  <= c_gnt ? bus.c_wdata : bus.h_wdata;
      end
      vld_q      <= vld_sh[RD_LAT-1:0];
      tag_q      <= tag_sh[RD_LAT-1:0];
      h_rvalid_q <= vld_q[RD_LAT-1] && !tag_q[RD_LAT-1];
      c_rvalid_q <= vld_q[RD_LAT-1] && tag_q[RD_LAT-1];
      if (vld_q[RD_LAT-1] && !tag_q[RD_LAT-1]) h_rdata_q <= bus.dout_bram;
      if (vld_q[RD_LAT-1] && tag_q[RD_LAT-1])  c_rdata_q <= bus.dout_bram;
    end
  end
  assign bus.h_gnt     = h_gnt;
  assign bus.c_gnt     = c_gnt;
  assign bus.h_rvalid  = h_rvalid_q;
  assign bus.c_rvalid  = c_rvalid_q;
  assign bus.h_rdata   = h_rdata_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.en_bram   = en_q;
  assign bus.we_bram   = we_q;
  assign bus.addr_bram = addr_q;
  assign bus.din_bram  = din_q;
endmodule
